// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants, FSM state type and the full-width multiply helper.
package ntt_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned RED_ITERS = 64;
    localparam int unsigned CNT_W     = $clog2(RED_ITERS);

    typedef enum logic [3:0] {
        StIdle,
        StMul,
        StRed,
        StAddSub,
        StSmulL,
        StSredL,
        StSmulR,
        StSredR,
        StDone
    } state_e;

    function automatic logic [PROD_W-1:0] mul_full(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
        return {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    endfunction

endpackage

// File: rtl/intt_butterfly_seq_if.sv
// Operand/result handshake bundle for intt_butterfly_seq; n_inv exists only with INTT_SCALE_EN.
interface intt_butterfly_seq_if;
    import ntt_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] q;
`ifdef INTT_SCALE_EN
    logic [WIDTH-1:0] n_inv;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Left;
    logic [WIDTH-1:0] Right;

`ifdef INTT_SCALE_EN
    modport master (output in_valid, W, A, B, q, n_inv, out_ready,
                    input  in_ready, out_valid, Left, Right);
    modport slave  (input  in_valid, W, A, B, q, n_inv, out_ready,
                    output in_ready, out_valid, Left, Right);
`else
    modport master (output in_valid, W, A, B, q, out_ready,
                    input  in_ready, out_valid, Left, Right);
    modport slave  (input  in_valid, W, A, B, q, out_ready,
                    output in_ready, out_valid, Left, Right);
`endif

endinterface

// File: rtl/mod_reduce_serial.sv
// Bit-serial restoring reducer: r = x mod q over RED_ITERS cycles, MSB first.
// done pulses during the final iteration; r then carries that iteration's result.
module mod_reduce_serial
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROD_W-1:0] x,
    input  logic [WIDTH-1:0]  q,
    output logic              done,
    output logic [WIDTH-1:0]  r
);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_next;

    // Bit index counts down from PROD_W-1, i.e. the complement of the iteration counter.
    always_comb begin
        r_shift = {r_q, x[~cnt_q]};
        r_next  = (r_shift >= {1'b0, q}) ? WIDTH'(r_shift - {1'b0, q}) : r_shift[WIDTH-1:0];
        done    = busy_q && (cnt_q == CNT_W'(RED_ITERS - 1));
        r       = r_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            r_q   <= r_next;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/intt_butterfly_seq.sv
// Sequential Cooley-Tukey butterfly: Left = (A + W*B) mod q, Right = (A - W*B) mod q.
// Define INTT_SCALE_EN to scale both results by n_inv through the same reducer.
module intt_butterfly_seq (
    input logic                 clk,
    input logic                 rst_n,
    intt_butterfly_seq_if.slave bus
);
    import ntt_pkg::*;

    state_e             state_q;
    logic [WIDTH-1:0]   w_q, a_q, b_q, q_q, t_q, left_q, right_q;
`ifdef INTT_SCALE_EN
    logic [WIDTH-1:0]   n_inv_q;
`endif
    logic [PROD_W-1:0]  prod_q;
    logic               out_valid_q;
    logic               red_start, red_done;
    logic [WIDTH-1:0]   red_r;
    logic [WIDTH:0]     sum, q_ext;
    logic [WIDTH-1:0]   add_l, sub_r;

    always_comb begin
        q_ext     = {1'b0, q_q};
        sum       = {1'b0, a_q} + {1'b0, t_q};
        add_l     = (sum >= q_ext) ? WIDTH'(sum - q_ext) : sum[WIDTH-1:0];
        sub_r     = (a_q >= t_q) ? WIDTH'({1'b0, a_q} - {1'b0, t_q})
                                 : WIDTH'({1'b0, a_q} + q_ext - {1'b0, t_q});
        red_start = (state_q == StMul) || (state_q == StSmulL) || (state_q == StSmulR);
    end

    mod_reduce_serial u_reduce (
        .clk   (clk),
        .rst_n (rst_n),
        .start (red_start),
        .x     (prod_q),
        .q     (q_q),
        .done  (red_done),
        .r     (red_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            w_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            q_q         <= '0;
`ifdef INTT_SCALE_EN
            n_inv_q     <= '0;
`endif
            t_q         <= '0;
            prod_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: if (bus.in_valid) begin
                    w_q     <= bus.W;
                    a_q     <= bus.A;
                    b_q     <= bus.B;
                    q_q     <= bus.q;
`ifdef INTT_SCALE_EN
                    n_inv_q <= bus.n_inv;
`endif
                    state_q <= StMul;
                end
                StMul: begin
                    prod_q  <= mul_full(w_q, b_q);
                    state_q <= StRed;
                end
                StRed: if (red_done) begin
                    t_q     <= red_r;
                    state_q <= StAddSub;
                end
                StAddSub: begin
                    left_q  <= add_l;
                    right_q <= sub_r;
`ifdef INTT_SCALE_EN
                    state_q <= StSmulL;
`else
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
`endif
                end
`ifdef INTT_SCALE_EN
                StSmulL: begin
                    prod_q  <= mul_full(left_q, n_inv_q);
                    state_q <= StSredL;
                end
                StSredL: if (red_done) begin
                    left_q  <= red_r;
                    state_q <= StSmulR;
                end
                StSmulR: begin
                    prod_q  <= mul_full(right_q, n_inv_q);
                    state_q <= StSredR;
                end
                StSredR: if (red_done) begin
                    right_q     <= red_r;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
`endif
                StDone: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.Left      = left_q;
    assign bus.Right     = right_q;

endmodule

// File: tb/tb_intt_butterfly_seq.sv
// Self-checking bench for intt_butterfly_seq against a modular-arithmetic reference model.
module tb_intt_butterfly_seq;

`ifdef INTT_SCALE_EN
    localparam int LAT = 196;
    logic [31:0] cur_ninv;
`else
    localparam int LAT = 66;
`endif
    localparam int LIMIT = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    intt_butterfly_seq_if bus();

    intt_butterfly_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit modular arithmetic.
    function automatic void model(input logic [31:0] w, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] qq,
                                  output logic [31:0] l, output logic [31:0] r);
        longint unsigned t, lv, rv, qm;
        qm = 64'(qq);
        t  = (64'(w) * 64'(b)) % qm;
        lv = (64'(a) + t) % qm;
        rv = (64'(a) + qm - t) % qm;
`ifdef INTT_SCALE_EN
        lv = (lv * 64'(cur_ninv)) % qm;
        rv = (rv * 64'(cur_ninv)) % qm;
`endif
        l = lv[31:0];
        r = rv[31:0];
    endfunction

    task automatic run_op(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] qq, output logic [31:0] l, output logic [31:0] r,
                          output int edges);
        bus.W = w; bus.A = a; bus.B = b; bus.q = qq;
`ifdef INTT_SCALE_EN
        bus.n_inv = cur_ninv;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < LIMIT) begin
            @(posedge clk); #1;
            edges++;
        end
        l = bus.Left;
        r = bus.Right;
        if (bus.out_ready === 1'b1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.Left !== 32'd0) begin errors++;
            $display("FAIL reset_left: got %0d expected 0", bus.Left); end
        checks++; if (bus.Right !== 32'd0) begin errors++;
            $display("FAIL reset_right: got %0d expected 0", bus.Right); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
`ifdef INTT_SCALE_EN
        logic [31:0] tw[1] = '{32'd3};
        logic [31:0] ta[1] = '{32'd5};
        logic [31:0] tb[1] = '{32'd7};
        logic [31:0] tq[1] = '{32'd17};
        logic [31:0] el[1] = '{32'd15};
        logic [31:0] er[1] = '{32'd13};
        cur_ninv = 32'd13;
`else
        logic [31:0] tw[3] = '{32'd3, 32'd16, 32'd4294967290};
        logic [31:0] ta[3] = '{32'd5, 32'd16, 32'd4294967290};
        logic [31:0] tb[3] = '{32'd7, 32'd16, 32'd4294967290};
        logic [31:0] tq[3] = '{32'd17, 32'd17, 32'd4294967291};
        logic [31:0] el[3] = '{32'd9, 32'd0, 32'd0};
        logic [31:0] er[3] = '{32'd1, 32'd15, 32'd4294967289};
`endif
        logic [31:0] l, r;
        int edges;
        for (int i = 0; i < $size(tw); i++) begin
            run_op(tw[i], ta[i], tb[i], tq[i], l, r, edges);
            checks++; if (edges !== LAT) begin errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, edges, LAT); end
            checks++; if (l !== el[i]) begin errors++;
                $display("FAIL directed_left[%0d]: got %0d expected %0d", i, l, el[i]); end
            checks++; if (r !== er[i]) begin errors++;
                $display("FAIL directed_right[%0d]: got %0d expected %0d", i, r, er[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] qq, w, a, b, l, r, el, er;
        int edges;
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: qq = $urandom_range(64, 2);
                1: begin qq = $urandom; if (qq < 32'd2) qq = 32'd2; end
                default: qq = 32'hFFFF_FFFF - $urandom_range(100, 0);
            endcase
            w = $urandom % qq; a = $urandom % qq; b = $urandom % qq;
`ifdef INTT_SCALE_EN
            cur_ninv = $urandom % qq;
`endif
            model(w, a, b, qq, el, er);
            run_op(w, a, b, qq, l, r, edges);
            checks++; if (edges !== LAT) begin errors++;
                $display("FAIL random_latency[%0d]: got %0d expected %0d", i, edges, LAT); end
            checks++; if (l !== el || r !== er) begin errors++;
                $display("FAIL random_result[%0d] q=%0d W=%0d A=%0d B=%0d: got L=%0d R=%0d expected L=%0d R=%0d",
                         i, qq, w, a, b, l, r, el, er); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] l0, r0, el, er;
        int edges;
`ifdef INTT_SCALE_EN
        cur_ninv = 32'd13;
`endif
        bus.out_ready = 1'b0;
        model(32'd3, 32'd5, 32'd7, 32'd17, el, er);
        run_op(32'd3, 32'd5, 32'd7, 32'd17, l0, r0, edges);
        checks++; if (l0 !== el || r0 !== er) begin errors++;
            $display("FAIL bp_result: got L=%0d R=%0d expected L=%0d R=%0d", l0, r0, el, er); end
        // Offer a new operand set while the result is stalled.
        bus.W = 32'd2; bus.A = 32'd10; bus.B = 32'd3; bus.q = 32'd101;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.Left !== l0 || bus.Right !== r0 || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got L=%0d R=%0d ov=%b ir=%b expected L=%0d R=%0d ov=1 ir=0",
                         c, bus.Left, bus.Right, bus.out_valid, bus.in_ready, l0, r0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1",
                     bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < LIMIT) begin
            @(posedge clk); #1;
            edges++;
        end
        model(32'd2, 32'd10, 32'd3, 32'd101, el, er);
        checks++; if (edges !== LAT) begin errors++;
            $display("FAIL bp_next_latency: got %0d expected %0d", edges, LAT); end
        checks++; if (bus.Left !== el || bus.Right !== er) begin errors++;
            $display("FAIL bp_next_result: got L=%0d R=%0d expected L=%0d R=%0d",
                     bus.Left, bus.Right, el, er); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] l, r, el, er;
        int edges;
        bus.W = 32'd9; bus.A = 32'd4; bus.B = 32'd11; bus.q = 32'd97;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_handshake: got ir=%b ov=%b expected ir=1 ov=0",
                     bus.in_ready, bus.out_valid); end
        checks++; if (bus.Left !== 32'd0 || bus.Right !== 32'd0) begin errors++;
            $display("FAIL midreset_outputs: got L=%0d R=%0d expected 0 0", bus.Left, bus.Right); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_no_stale: got ov=%b expected 0", bus.out_valid); end
        model(32'd16, 32'd16, 32'd16, 32'd17, el, er);
        run_op(32'd16, 32'd16, 32'd16, 32'd17, l, r, edges);
        checks++; if (edges !== LAT || l !== el || r !== er) begin errors++;
            $display("FAIL midreset_fresh: got lat=%0d L=%0d R=%0d expected lat=%0d L=%0d R=%0d",
                     edges, l, r, LAT, el, er); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] qq, w, a, b, l, r, el, er;
        int edges;
        for (int i = 0; i < 4; i++) begin
            qq = $urandom_range(100000, 3);
            w = $urandom % qq; a = $urandom % qq; b = $urandom % qq;
`ifdef INTT_SCALE_EN
            cur_ninv = $urandom % qq;
`endif
            checks++; if (bus.in_ready !== 1'b1) begin errors++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            model(w, a, b, qq, el, er);
            run_op(w, a, b, qq, l, r, edges);
            checks++; if (edges !== LAT || l !== el || r !== er) begin errors++;
                $display("FAIL b2b_result[%0d]: got lat=%0d L=%0d R=%0d expected lat=%0d L=%0d R=%0d",
                         i, edges, l, r, LAT, el, er); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.W = '0; bus.A = '0; bus.B = '0; bus.q = 32'd2;
`ifdef INTT_SCALE_EN
        cur_ninv  = 32'd1;
        bus.n_inv = 32'd1;
`endif
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
